tea_cbc_stream: RTL and testbench

Byte-stream front/back end for the `tea_enc_dec` core. It packs an 8-bit valid/ready input stream into 64-bit blocks and applies CBC chaining with a loadable IV. It drives the core's `in`/`mode`/`write` ports, waits for the core's `out_ready`, and serializes the result back to an 8-bit valid/ready output stream. The core's 128-bit key is owned and loaded elsewhere; this block never touches it.

---
 rtl/tea_pkg.sv | 15 +
 rtl/tea_byte_shifter.sv | 29 ++
 rtl/tea_cbc_stream.sv | 121 ++++++++++++
 tb/tb_tea_cbc_stream.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared constants and FSM encoding for the TEA byte-stream wrapper.
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E37_79B9;
  localparam int BLOCK_W = 64;
  localparam int BYTES_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/tea_byte_shifter.sv
// 64-bit register that loads a whole block or shifts a byte in at the bottom,
// with a 3-bit count of shifts since the last load.
module tea_byte_shifter
  import tea_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [7:0]         shift_in,
  output logic [BLOCK_W-1:0] data,
  output logic [2:0]         count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift) begin
      data  <= {data[BLOCK_W-9:0], shift_in};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/tea_cbc_stream.sv
// Byte-stream front/back end for the TEA core: packs bytes into 64-bit blocks,
// applies CBC/ECB chaining around one core operation, and serializes the result.
//   state    | meaning
//   ST_FILL  | accepting input bytes into blk; iv_load honoured at count 0
//   ST_START | one-cycle core write with the (chained) block
//   ST_WAIT  | waiting for core out_ready, then latch result into obuf
//   ST_DRAIN | emitting obuf bytes, MSB first
module tea_cbc_stream
  import tea_pkg::*;
#(
  parameter bit CBC = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               mode_in,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BLOCK_W-1:0] core_in,
  output logic               core_mode,
  output logic               core_write,
  input  logic [BLOCK_W-1:0] core_out,
  input  logic               core_ready
);

  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_BLOCK - 1);

  state_t             state, state_next;
  logic [BLOCK_W-1:0] blk, obuf, obuf_next, chain, cprev;
  logic [2:0]         in_cnt, out_cnt;
  logic               mode, run;
  logic               in_fire, out_fire, core_done, iv_take;

  assign in_fire   = s_valid && run && (state == ST_FILL);
  assign out_fire  = m_ready && (state == ST_DRAIN);
  assign core_done = core_ready && (state == ST_WAIT);
  assign iv_take   = iv_load && (state == ST_FILL) && (in_cnt == 3'd0);
  assign obuf_next = (CBC && mode) ? (core_out ^ chain) : core_out;

  tea_byte_shifter u_in_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_fire),
    .shift_in  (s_data),
    .data      (blk),
    .count     (in_cnt)
  );

  tea_byte_shifter u_out_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (core_done),
    .load_data (obuf_next),
    .shift     (out_fire),
    .shift_in  (8'h00),
    .data      (obuf),
    .count     (out_cnt)
  );

  // Lower obuf bytes only reach m_data after shifting up to the top.
  logic unused_obuf;
  assign unused_obuf = ^obuf[BLOCK_W-9:0];

  assign m_data    = obuf[BLOCK_W-1:BLOCK_W-8];
  assign core_mode = mode;
  assign core_in   = (state != ST_START) ? '0 :
                     (CBC && !mode)      ? (blk ^ chain) : blk;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FILL;
      chain <= '0;
      cprev <= '0;
      mode  <= 1'b0;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      run   <= 1'b1;
      if (iv_take) begin
        chain <= iv;
        mode  <= mode_in;
      end
      if (state == ST_START) cprev <= blk;
      // Decrypt chains on the ciphertext that went in, encrypt on what came out.
      if (core_done) chain <= mode ? cprev : core_out;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    core_write = 1'b0;
    case (state)
      ST_FILL: begin
        s_ready = run;
        if (in_fire && (in_cnt == LAST_BYTE)) state_next = ST_START;
      end
      ST_START: begin
        core_write = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        m_valid = 1'b1;
        if (out_fire && (out_cnt == LAST_BYTE)) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

endmodule

// File: tb/tb_tea_cbc_stream.sv
// Self-checking bench for tea_cbc_stream with a behavioural TEA core (key 0)
// and a byte scoreboard on the output stream.
module tb_tea_cbc_stream;

  localparam logic [31:0] DLT = 32'h9E3779B9;
  localparam logic [31:0] K0 = 32'h0, K1 = 32'h0, K2 = 32'h0, K3 = 32'h0;
  localparam logic [63:0] KAT0 = 64'h41EA3A0A94BAA940;

  logic        clk = 1'b0, reset = 1'b1;
  logic        iv_load = 1'b0, mode_in = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [63:0] iv = '0;
  logic [7:0]  s_data = '0;
  logic        s_ready, m_valid, core_mode, core_write;
  logic [7:0]  m_data;
  logic [63:0] core_in;
  logic [63:0] core_out = '0, core_res = '0;
  logic        core_ready = 1'b0;
  int          core_cnt = 0;

  int          n_checks = 0, n_pass = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] mdl_chain, ct1, ct2;
  logic        mdl_mode;

  tea_cbc_stream #(.CBC(1'b1)) dut (
    .clk(clk), .reset(reset), .iv_load(iv_load), .iv(iv), .mode_in(mode_in),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_in(core_in), .core_mode(core_mode), .core_write(core_write),
    .core_out(core_out), .core_ready(core_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tea_enc(input logic [63:0] b);
    logic [31:0] v0 = b[63:32], v1 = b[31:0], sum = 32'h0;
    for (int i = 0; i < 32; i++) begin
      sum += DLT;
      v0 += ((v1 << 4) + K0) ^ (v1 + sum) ^ ((v1 >> 5) + K1);
      v1 += ((v0 << 4) + K2) ^ (v0 + sum) ^ ((v0 >> 5) + K3);
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] b);
    logic [31:0] v0 = b[63:32], v1 = b[31:0], sum = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1 -= ((v0 << 4) + K2) ^ (v0 + sum) ^ ((v0 >> 5) + K3);
      v0 -= ((v1 << 4) + K0) ^ (v1 + sum) ^ ((v1 >> 5) + K1);
      sum -= DLT;
    end
    return {v0, v1};
  endfunction

  // Core stand-in: result and out_ready appear 33 edges after the write edge.
  always @(posedge clk) begin
    if (core_write === 1'b1) begin
      core_res   <= core_mode ? tea_dec(core_in) : tea_enc(core_in);
      core_ready <= 1'b0;
      core_cnt   <= 33;
    end else if (core_cnt == 1) begin
      core_ready <= 1'b1;
      core_out   <= core_res;
      core_cnt   <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  // Scoreboard: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!reset && m_valid === 1'b1 && m_ready) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("FAIL out_byte unexpected byte got %02h want none", m_data);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) $display("FAIL out_byte got %02h want %02h", m_data, e);
        else n_pass++;
      end
    end
  end

  function automatic logic [63:0] model_block(input logic [63:0] pt);
    logic [63:0] r;
    if (!mdl_mode) begin
      r = tea_enc(pt ^ mdl_chain);
      mdl_chain = r;
    end else begin
      r = tea_dec(pt) ^ mdl_chain;
      mdl_chain = pt;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [63:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[63-8*i -: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ld, input logic [63:0] ivv,
                           input logic md);
    int n = 0;
    s_data = b; s_valid = 1'b1; iv_load = ld; iv = ivv; mode_in = md;
    while (s_ready !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL s_ready_timeout got %b want 1", s_ready);
    end
    step();
    s_valid = 1'b0; iv_load = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] pt);
    for (int i = 0; i < 8; i++) send_byte(pt[63-8*i -: 8], 1'b0, '0, 1'b0);
  endtask

  task automatic load_iv(input logic [63:0] ivv, input logic md);
    iv_load = 1'b1; iv = ivv; mode_in = md;
    step();
    iv_load = 1'b0;
    mdl_chain = ivv; mdl_mode = md;
  endtask

  task automatic wait_drain();
    int n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < 300) begin step(); n++; end
    n_checks++;
    if (n >= 300) $display("FAIL drain_timeout got %0d bytes pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'h00) $display("FAIL rst_m_data got %02h want 00", m_data); else n_pass++;
    n_checks++; if (core_write !== 1'b0) $display("FAIL rst_core_write got %b want 0", core_write); else n_pass++;
    n_checks++; if (core_in !== 64'h0) $display("FAIL rst_core_in got %016h want 0", core_in); else n_pass++;
    n_checks++; if (core_mode !== 1'b0) $display("FAIL rst_core_mode got %b want 0", core_mode); else n_pass++;
    reset = 1'b0;
    step();
    n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready got %b want 1", s_ready); else n_pass++;
    mdl_chain = '0; mdl_mode = 1'b0;
  endtask

  task automatic test_first_block();
    int n = 0;
    logic s_ready_seen = 1'b0;
    m_ready = 1'b1;
    push_block(KAT0);
    mdl_chain = KAT0;
    send_block(64'h0);
    n_checks++; if (core_write !== 1'b1) $display("FAIL start_core_write got %b want 1", core_write); else n_pass++;
    n_checks++; if (core_in !== 64'h0) $display("FAIL start_core_in got %016h want 0", core_in); else n_pass++;
    n_checks++; if (core_mode !== 1'b0) $display("FAIL start_core_mode got %b want 0", core_mode); else n_pass++;
    while (m_valid !== 1'b1 && n < 100) begin
      step(); n++;
      if (n == 1) begin
        n_checks++;
        if (core_write !== 1'b0) $display("FAIL write_pulse got %b want 0", core_write); else n_pass++;
      end
      if (s_ready !== 1'b0) s_ready_seen = 1'b1;
    end
    n_checks++; if (n != 35) $display("FAIL latency got %0d want 35", n); else n_pass++;
    n_checks++; if (s_ready_seen) $display("FAIL busy_s_ready got 1 want 0"); else n_pass++;
    wait_drain();
    ct1 = KAT0;
  endtask

  task automatic test_cbc_encrypt();
    ct2 = model_block(64'h0);
    push_block(ct2);
    send_block(64'h0);
    wait_drain();
  endtask

  task automatic test_cbc_decrypt();
    logic [63:0] r;
    load_iv(64'h0, 1'b1);
    push_block(64'h0);
    push_block(64'h0);
    r = model_block(ct1);
    r = model_block(ct2);
    send_block(ct1);
    send_block(ct2);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] pt, e;
    logic v, r;
    logic [7:0] d;
    int n = 0;
    load_iv({$urandom, $urandom}, 1'b0);
    pt = {$urandom, $urandom};
    e = model_block(pt);
    push_block(e);
    m_ready = 1'b0;
    send_block(pt);
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < 400) begin
      v = m_valid; d = m_data;
      m_ready = 1'($urandom_range(0, 1));
      r = m_ready;
      if (v) begin
        n_checks++;
        if (s_ready !== 1'b0) $display("FAIL bp_s_ready got %b want 0", s_ready); else n_pass++;
      end
      step(); n++;
      if (v && !r) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== d)
          $display("FAIL bp_hold got %b/%02h want 1/%02h", m_valid, m_data, d);
        else n_pass++;
      end
    end
    n_checks++;
    if (n >= 400) $display("FAIL bp_timeout got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_iv_load();
    logic [63:0] pt, e, iv_c;
    load_iv(64'h0123456789ABCDEF, 1'b0);
    pt = {$urandom, $urandom};
    e = model_block(pt);
    push_block(e);
    for (int i = 0; i < 8; i++)
      send_byte(pt[63-8*i -: 8], (i == 3), 64'hFEDCBA9876543210, 1'b1);
    wait_drain();
    iv_c = {$urandom, $urandom};
    mdl_chain = iv_c; mdl_mode = 1'b0;
    pt = {$urandom, $urandom};
    e = model_block(pt);
    push_block(e);
    for (int i = 0; i < 8; i++) send_byte(pt[63-8*i -: 8], (i == 0), iv_c, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_in_wait();
    logic seen = 1'b0;
    m_ready = 1'b1;
    send_block({$urandom, $urandom});
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    n_checks++; if (m_valid !== 1'b0) $display("FAIL wait_rst_m_valid got %b want 0", m_valid); else n_pass++;
    reset = 1'b0;
    step();
    n_checks++; if (s_ready !== 1'b1) $display("FAIL wait_rst_s_ready got %b want 1", s_ready); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) $display("FAIL late_core_ready got m_valid 1 want 0"); else n_pass++;
    mdl_chain = '0; mdl_mode = 1'b0;
    push_block(model_block(64'h0));
    send_block(64'h0);
    wait_drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_block();
    test_cbc_encrypt();
    test_cbc_decrypt();
    test_backpressure();
    test_iv_load();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
